cs_loader: RTL and testbench

CS_LOADER -- requirements
Module: cs_loader

---
 rtl/cs_loader_if.sv | 31 +++
 rtl/cs_loader.sv | 162 ++++++++++++++++
 tb/tb_cs_loader.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cs_loader_if.sv
// cs_loader_if -- bus between the control store loader, the microcode EPROM
// and the control store RAM.
//
// Handshake: there is no back-pressure on this bus. cs_ram__w low for one
// cycle marks a valid write of ram_data_out to cs_addr, and the RAM must
// accept it in that cycle. EPROM and RAM reads are plain addressed reads that
// are sampled a fixed number of cycles after cs_addr settles. cs_ready high
// hands ownership of the control store address to the sequencer. cs_error
// high reports a failed verify. The two flags are never high together.
interface cs_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] cs_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic [DATA_WIDTH-1:0] ram_data_out;
  logic [DATA_WIDTH-1:0] ram_data_in;
  logic                  cs_ram__w;
  logic                  cs_ready;
  logic                  cs_error;

  modport master (
    output cs_addr, ram_data_out, cs_ram__w, cs_ready, cs_error,
    input  rom_data, ram_data_in
  );

  modport slave (
    input  cs_addr, ram_data_out, cs_ram__w, cs_ready, cs_error,
    output rom_data, ram_data_in
  );
endinterface

// File: rtl/cs_loader.sv
// cs_loader -- copies the microcode EPROM into the control store RAM after
// reset, one word per WAIT_CYCLES+4 cycles. It then either hands the store to
// the sequencer (cs_ready) or, with CS_LOADER_VERIFY_EN defined, first reads
// every word back and compares it against the EPROM. A mismatch parks the
// loader in ERROR with the failing address on cs_addr.
// Optional feature macro: CS_LOADER_VERIFY_EN (verify pass).
module cs_loader #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 64,
  parameter int WAIT_CYCLES = 1   // extra EPROM access cycles, 0..7
) (
  input  logic        clk,
  input  logic        _reset,
  cs_loader_if.master bus,
  output logic [3:0]  o_dbg_state
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    LATCH  = 4'd2,
    WRITE  = 4'd3,
    HOLD   = 4'd4,
`ifdef CS_LOADER_VERIFY_EN
    VFETCH = 4'd5,
    VCMP   = 4'd6,
    ERROR  = 4'd8,
`endif
    DONE   = 4'd7
  } state_t;

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [2:0]            r_wait;
  logic                  r_we_n;
  logic                  r_ready;
  logic                  w_addr_last;
  logic                  w_wait_done;

  assign w_addr_last = &r_addr;
  assign w_wait_done = (r_wait == WAIT_LAST);

`ifdef CS_LOADER_VERIFY_EN
  logic w_match;
  logic r_error;
  assign w_match = (bus.rom_data == bus.ram_data_in);
`else
  // The read-back path exists only for the verify pass.
  logic w_unused;
  assign w_unused = ^bus.ram_data_in;
`endif

  // State register.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  w_next = FETCH;
      FETCH: if (w_wait_done) w_next = LATCH;
      LATCH: w_next = WRITE;
      WRITE: w_next = HOLD;
      HOLD: begin
        if (w_addr_last) begin
`ifdef CS_LOADER_VERIFY_EN
          w_next = VFETCH;
`else
          w_next = DONE;
`endif
        end else begin
          w_next = FETCH;
        end
      end
`ifdef CS_LOADER_VERIFY_EN
      VFETCH: if (w_wait_done) w_next = VCMP;
      VCMP: begin
        if (!w_match)         w_next = ERROR;
        else if (w_addr_last) w_next = DONE;
        else                  w_next = VFETCH;
      end
      ERROR: w_next = ERROR;
`endif
      DONE:    w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  // Address, data and access-wait counter; the address never wraps because
  // the all-ones word leaves the load loop instead of incrementing.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      r_addr <= '0;
      r_data <= '0;
      r_wait <= 3'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_addr <= '0;
          r_wait <= 3'd0;
        end
        FETCH: r_wait <= w_wait_done ? 3'd0 : r_wait + 3'd1;
        LATCH: r_data <= bus.rom_data;
        HOLD: begin
          if (!w_addr_last) begin
            r_addr <= r_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          end else begin
`ifdef CS_LOADER_VERIFY_EN
            r_addr <= '0;
`endif
          end
        end
`ifdef CS_LOADER_VERIFY_EN
        VFETCH: r_wait <= w_wait_done ? 3'd0 : r_wait + 3'd1;
        VCMP: begin
          if (w_match && !w_addr_last) begin
            r_addr <= r_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Status outputs registered from the next state so they change cleanly on
  // the same edge as the state they describe.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      r_we_n  <= 1'b1;
      r_ready <= 1'b0;
    end else begin
      r_we_n  <= (w_next != WRITE);
      r_ready <= (w_next == DONE);
    end
  end

`ifdef CS_LOADER_VERIFY_EN
  // Error flag, set only on entry to ERROR.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) r_error <= 1'b0;
    else         r_error <= (w_next == ERROR);
  end
  assign bus.cs_error = r_error;
`else
  assign bus.cs_error = 1'b0;
`endif

  assign bus.cs_addr      = r_addr;
  assign bus.ram_data_out = r_data;
  assign bus.cs_ram__w    = r_we_n;
  assign bus.cs_ready     = r_ready;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_cs_loader.sv
// tb_cs_loader -- bench for cs_loader. Two loaders share the clock: dut_a with
// WAIT_CYCLES=1 and dut_b with WAIT_CYCLES=0. The EPROM models return
// {8{addr}}. Each RAM model records every write.
`timescale 1ns/1ps
module tb_cs_loader;
  localparam int AW = 8;
  localparam int DW = 64;
`ifdef CS_LOADER_VERIFY_EN
  localparam int EXP_EDGE_A = 2049;
  localparam int EXP_EDGE_B = 1537;
`else
  localparam int EXP_EDGE_A = 1281;
  localparam int EXP_EDGE_B = 1025;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a;
  logic rst_b;
  int   cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  cs_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
  cs_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();
  logic [3:0] dbg_a;
  logic [3:0] dbg_b;

  cs_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(1)) dut_a (
    .clk(clk), ._reset(rst_a), .bus(bus_a), .o_dbg_state(dbg_a)
  );
  cs_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), ._reset(rst_b), .bus(bus_b), .o_dbg_state(dbg_b)
  );

  // ---------------- memory models ----------------
  logic [DW-1:0] ram_a [256];
  logic [DW-1:0] ram_b [256];
  bit corrupt = 1'b0;

  assign bus_a.rom_data    = {8{bus_a.cs_addr}};
  assign bus_b.rom_data    = {8{bus_b.cs_addr}};
  assign bus_a.ram_data_in = ram_a[bus_a.cs_addr] ^
                             ((corrupt && bus_a.cs_addr == 8'h7F) ? 64'h1 : 64'h0);
  assign bus_b.ram_data_in = ram_b[bus_b.cs_addr];

  // ---------------- check helpers ----------------
  task automatic check_vec(input string name, input logic [AW+DW-1:0] act,
                           input logic [AW+DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [AW+DW-1:0] exp_q[$];
  int pulses_a = 0;
  int pulses_b = 0;
  int last_b = -1;
  int spacing_err = 0;
  int both_high = 0;

  task automatic push_expected();
    exp_q.delete();
    for (int n = 0; n < 256; n++) begin
      logic [7:0] a;
      a = n[7:0];
      exp_q.push_back({a, {8{a}}});
    end
  endtask

  // Writes on dut_a are popped against the expected queue.
  always @(negedge clk) begin
    if (rst_a && bus_a.cs_ram__w == 1'b0) begin
      pulses_a++;
      ram_a[bus_a.cs_addr] = bus_a.ram_data_out;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write_a: addr %0h data %0h, expected no write",
                 bus_a.cs_addr, bus_a.ram_data_out);
      end else begin
        check_vec("write_a", {bus_a.cs_addr, bus_a.ram_data_out}, exp_q.pop_front());
      end
    end
  end

  // Writes on dut_b are counted and their spacing is tracked.
  always @(negedge clk) begin
    if (rst_b && bus_b.cs_ram__w == 1'b0) begin
      pulses_b++;
      ram_b[bus_b.cs_addr] = bus_b.ram_data_out;
      if (last_b >= 0 && (cyc - last_b) != 4) spacing_err++;
      last_b = cyc;
    end
  end

  // cs_ready and cs_error must never be high together.
  always @(negedge clk) begin
    if ((bus_a.cs_ready && bus_a.cs_error) || (bus_b.cs_ready && bus_b.cs_error))
      both_high++;
  end

  // Counts rising edges from the call until cs_ready is seen high; 0 on timeout.
  task automatic wait_ready(input int sel, input int bound, output int edges);
    logic rdy;
    edges = 0;
    for (int i = 1; i <= bound; i++) begin
      @(posedge clk);
      #1;
      rdy = (sel == 0) ? bus_a.cs_ready : bus_b.cs_ready;
      if (rdy) begin
        edges = i;
        break;
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]    addr;
    logic [DW-1:0] data;
  } vec_t;
  vec_t vecs[6];

  // ---------------- main sequence ----------------
  initial begin
    int edges;
    int p;
    bit found;

    vecs[0] = '{8'h00, 64'h0000_0000_0000_0000};
    vecs[1] = '{8'h01, 64'h0101_0101_0101_0101};
    vecs[2] = '{8'h40, 64'h4040_4040_4040_4040};
    vecs[3] = '{8'h7F, 64'h7F7F_7F7F_7F7F_7F7F};
    vecs[4] = '{8'hFE, 64'hFEFE_FEFE_FEFE_FEFE};
    vecs[5] = '{8'hFF, 64'hFFFF_FFFF_FFFF_FFFF};

    for (int i = 0; i < 256; i++) begin
      ram_a[i] = '0;
      ram_b[i] = '0;
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_int("rst_addr",  int'(bus_a.cs_addr), 0);
    check_vec("rst_data",  {8'h00, bus_a.ram_data_out}, '0);
    check_int("rst_we_n",  int'(bus_a.cs_ram__w), 1);
    check_int("rst_ready", int'(bus_a.cs_ready), 0);
    check_int("rst_error", int'(bus_a.cs_error), 0);
    check_int("rst_state", int'(dbg_a), 0);

    // Full load on dut_a.
    push_expected();
    pulses_a = 0;
    @(negedge clk);
    rst_a = 1'b1;
    wait_ready(0, 4000, edges);
    check_int("ready_edge_a", edges, EXP_EDGE_A);
    check_int("pulses_a", pulses_a, 256);
    check_int("queue_empty_a", exp_q.size(), 0);
    check_int("done_addr", int'(bus_a.cs_addr), 255);
    check_vec("done_data", {8'h00, bus_a.ram_data_out}, {8'h00, 64'hFFFF_FFFF_FFFF_FFFF});
    check_int("done_error", int'(bus_a.cs_error), 0);
    for (int i = 0; i < 6; i++)
      check_vec("ram_word", {vecs[i].addr, ram_a[vecs[i].addr]}, {vecs[i].addr, vecs[i].data});
    p = pulses_a;
    repeat (1000) @(posedge clk);
    #1;
    check_int("done_no_writes", pulses_a, p);
    check_int("done_ready_held", int'(bus_a.cs_ready), 1);
    check_int("done_we_n", int'(bus_a.cs_ram__w), 1);
    check_int("done_addr_held", int'(bus_a.cs_addr), 255);

    // Zero-wait load on dut_b.
    @(negedge clk);
    rst_b = 1'b1;
    wait_ready(1, 4000, edges);
    check_int("ready_edge_b", edges, EXP_EDGE_B);
    check_int("pulses_b", pulses_b, 256);
    check_int("spacing_b", spacing_err, 0);
    check_vec("ram_b_word_ff", {8'h00, ram_b[255]}, {8'h00, 64'hFFFF_FFFF_FFFF_FFFF});

    // Reset mid-load while writing word 0x40.
    @(negedge clk);
    rst_a = 1'b0;
    repeat (2) @(negedge clk);
    push_expected();
    pulses_a = 0;
    rst_a = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (bus_a.cs_addr == 8'h40 && bus_a.cs_ram__w == 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    check_int("found_write_40", int'(found), 1);
    rst_a = 1'b0;
    #1;
    check_int("abort_we_n", int'(bus_a.cs_ram__w), 1);
    check_int("abort_addr", int'(bus_a.cs_addr), 0);
    check_int("abort_state", int'(dbg_a), 0);
    check_vec("abort_data", {8'h00, bus_a.ram_data_out}, '0);
    repeat (3) @(negedge clk);
    push_expected();
    pulses_a = 0;
    rst_a = 1'b1;
    wait_ready(0, 4000, edges);
    check_int("reload_edge_a", edges, EXP_EDGE_A);
    check_int("reload_pulses_a", pulses_a, 256);
    check_int("reload_queue_empty", exp_q.size(), 0);

`ifdef CS_LOADER_VERIFY_EN
    // Verify pass against a RAM that corrupts word 0x7F.
    @(negedge clk);
    rst_a = 1'b0;
    corrupt = 1'b1;
    repeat (2) @(negedge clk);
    push_expected();
    pulses_a = 0;
    rst_a = 1'b1;
    edges = 0;
    for (int i = 1; i <= 4000; i++) begin
      @(posedge clk);
      #1;
      if (bus_a.cs_error) begin
        edges = i;
        break;
      end
    end
    check_int("error_edge", edges, 1665);
    check_int("error_ready", int'(bus_a.cs_ready), 0);
    check_int("error_addr", int'(bus_a.cs_addr), 127);
    p = pulses_a;
    repeat (100) @(posedge clk);
    #1;
    check_int("error_no_writes", pulses_a, p);
    check_int("error_pulses", pulses_a, 256);
    check_int("error_held", int'(bus_a.cs_error), 1);
    check_int("error_addr_held", int'(bus_a.cs_addr), 127);
    check_int("error_we_n", int'(bus_a.cs_ram__w), 1);
`endif

    check_int("ready_error_exclusive", both_high, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
